// File: rtl/button_debounce_if.sv
// Button debounce port bundle.
// Handshake: there is no valid/ready pair. btn_in is a free-running raw level
// sampled on every clk edge. btn_level, press_pulse and led_out are registered
// outputs that are valid on every cycle. dbg_state mirrors the FSM state.
interface button_debounce_if;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       led_out;
  logic [1:0] dbg_state;

  modport master (
    output btn_in,
    input  btn_level, press_pulse, led_out, dbg_state
  );

  modport slave (
    input  btn_in,
    output btn_level, press_pulse, led_out, dbg_state
  );
endinterface

// File: rtl/button_debounce.sv
// Push-button debouncer: two-flop synchronizer followed by a four-state
// qualification FSM. It produces a debounced level, a one-cycle press pulse
// and an LED drive.
// Optional feature macro: BUTTON_DEBOUNCE_TOGGLE_EN. When it is defined, each
// accepted press flips led_out. Otherwise led_out follows the debounced level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic               clk,
  input  logic               rst,
  button_debounce_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic                 r_level;
  logic                 w_level_nxt;
  logic                 r_pulse;
  logic                 w_pulse_nxt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic. A WAIT state only completes after DEBOUNCE_CYCLES more
  // stable samples. Any contrary sample drops back to the previous idle state.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_level_nxt = r_level;
    w_pulse_nxt = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (r_sync2) begin
          w_state_nxt = WAIT_HIGH;
          w_count_nxt = '0;
        end
      end
      WAIT_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE_LOW;
        end else if (r_count == LP_LAST) begin
          w_state_nxt = IDLE_HIGH;
          w_level_nxt = 1'b1;
          w_pulse_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = WAIT_LOW;
          w_count_nxt = '0;
        end
      end
      WAIT_LOW: begin
        if (r_sync2) begin
          w_state_nxt = IDLE_HIGH;
        end else if (r_count == LP_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_level_nxt = 1'b0;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_count_nxt = '0;
      end
    endcase
  end

  // FSM state, counter and registered outputs. Reset discards any pending change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE_LOW;
      r_count <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign bus.btn_level   = r_level;
  assign bus.press_pulse = r_pulse;
  assign bus.dbg_state   = r_state;

`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
  logic r_toggle;

  // Flip the LED on the same edge that raises press_pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_toggle <= 1'b0;
    end else if (w_pulse_nxt) begin
      r_toggle <= ~r_toggle;
    end
  end

  assign bus.led_out = r_toggle;
`else
  // In follow mode the LED is the debounced level register itself.
  assign bus.led_out = r_level;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce (DEBOUNCE_CYCLES=4, CNT_WIDTH=3). A reference
// model tracks how long the synchronized input has disagreed with the accepted
// level. It pushes the expected {led, pulse, level} for every edge into exp_q.
// A monitor pops and compares these values on the falling edge.
module tb_button_debounce;
  localparam int D = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   dut_pulses;
  logic [2:0] exp_q[$];

  button_debounce_if bus ();

  button_debounce #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock and reset drive.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  bit m_s1, m_s2, m_lvl, m_pulse, m_led;
  int m_run;

  task automatic model_step();
    bit b_smp;
    bit r_smp;
    b_smp = bus.btn_in;
    r_smp = rst;
    if (r_smp) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pulse = 0; m_led = 0; m_run = 0;
    end else begin
      m_pulse = 0;
      // A change is accepted on its (D+1)-th consecutive disagreeing sample.
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = m_s2;
          m_run = 0;
          if (m_lvl) begin
            m_pulse = 1;
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
            m_led = ~m_led;
`endif
          end
        end
      end else begin
        m_run = 0;
      end
`ifndef BUTTON_DEBOUNCE_TOGGLE_EN
      m_led = m_lvl;
`endif
      m_s2 = m_s1;
      m_s1 = b_smp;
    end
    exp_q.push_back({m_led, m_pulse, m_lvl});
  endtask

  // Model runs on each active edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compare the DUT outputs with the model on the opposite edge.
  initial begin
    logic [2:0] exp_v;
    forever begin
      @(negedge clk);
      if (bus.press_pulse === 1'b1) dut_pulses++;
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 32'd1, 32'd0);
      end else begin
        exp_v = exp_q.pop_front();
        chk("outputs", {29'd0, bus.led_out, bus.press_pulse, bus.btn_level}, {29'd0, exp_v});
      end
    end
  end

  // Driver tasks.
  task automatic hold(input bit v, input int n);
    bus.btn_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic settle_chk(input string name, input int p0, input int exp_n);
    #1;
    chk(name, dut_pulses - p0, exp_n);
  endtask

  initial begin
    int p0;
    tests = 0; fails = 0; dut_pulses = 0;
    rst = 1'b1;
    bus.btn_in = 1'b0;
    repeat (2) @(negedge clk);

    // Reset with the button held, then release reset.
    bus.btn_in = 1'b1;
    repeat (3) @(negedge clk);
    p0 = dut_pulses;
    rst = 1'b0;
    hold(1, 20);
    settle_chk("reset_held_pulse", p0, 1);
    hold(0, 20);

    // Clean press and release.
    p0 = dut_pulses;
    hold(1, 20);
    hold(0, 20);
    settle_chk("clean_press_pulse", p0, 1);

    // Short glitch.
    p0 = dut_pulses;
    hold(1, 4);
    hold(0, 20);
    settle_chk("glitch_pulse", p0, 0);

    // Bounce, then a steady press.
    p0 = dut_pulses;
    for (int i = 0; i < 10; i++) hold(bit'((i + 1) % 2), 1);
    hold(1, 20);
    hold(0, 20);
    settle_chk("bounce_pulse", p0, 1);

    // Two full press/release cycles.
    p0 = dut_pulses;
    for (int k = 0; k < 2; k++) begin
      hold(1, 20);
      hold(0, 20);
    end
    settle_chk("two_cycle_pulses", p0, 2);

    // Reset during WAIT_HIGH, then qualification restarts.
    p0 = dut_pulses;
    hold(1, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    settle_chk("reset_mid_no_pulse", p0, 0);
    hold(1, 20);
    settle_chk("reset_mid_restart", p0, 1);
    hold(0, 20);

    // Random segments with occasional resets.
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 14) == 0) rst = 1'b1;
      bus.btn_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      rst = 1'b0;
      hold(bus.btn_in, $urandom_range(0, 11));
    end
    hold(0, 20);

    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/button_debounce.md
# button_debounce

Conditions a raw, bouncing push-button input into a clean, synchronized LED drive signal. Sits directly upstream of the LED driver stage: its `led_out` feeds the driver's single-bit input. Provides a debounced level and a one-cycle press pulse for other consumers. An optional toggle mode turns each press into an LED on/off flip.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples required to accept a change. 10 ms at 50 MHz. Legal range ≥ 2.
- `CNT_WIDTH`, default 20: debounce counter width. Must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES-1.

- `clk`  in  1  single system clock, rising-edge active.
- `rst`  in  1  synchronous, active-high reset.
- `btn_in`  in  1  raw button, asynchronous to `clk`, may bounce.
- `btn_level`  out  1  debounced button level, registered.
- `press_pulse`  out  1  high for exactly one cycle per accepted press (0→1 change).
- `led_out`  out  1  LED drive to the downstream LED driver, registered.

## Operation
- Two-flop synchronizer, `sync1` → `sync2`. All logic uses `sync2` only.
- FSM states:
  - IDLE_LOW: stable released.
  - WAIT_HIGH: candidate press.
  - IDLE_HIGH: stable pressed.
  - WAIT_LOW: candidate release.
- Transitions, evaluated every edge:
  - IDLE_LOW: `sync2`=1 → WAIT_HIGH, count←0.
  - WAIT_HIGH:
    - `sync2`=0 → IDLE_LOW (glitch rejected).
    - else if count==DEBOUNCE_CYCLES-1 → IDLE_HIGH; `btn_level`←1, `press_pulse`←1.
    - else count←count+1.
  - IDLE_HIGH: `sync2`=0 → WAIT_LOW, count←0.
  - WAIT_LOW: mirror of WAIT_HIGH. Aborts to IDLE_HIGH on `sync2`=1. On completion → IDLE_LOW, `btn_level`←0. No pulse on release.
- Counter increments only in WAIT states. It is cleared on entering a WAIT state, so it never wraps.
- `press_pulse` is cleared on every edge where it is not being set. It can never be high for two consecutive cycles.
- `led_out` behaviour depends on the Configuration macro.
- Reset values (`rst`=1 at an edge, regardless of state or `btn_in`):
  - `sync1`=`sync2`=0, state=IDLE_LOW, count=0.
  - `btn_level`=0, `press_pulse`=0, `led_out`=0.
  - Reset during a WAIT state discards the pending change; no pulse is produced.

## Timing
- Press latency: take edge 1 as the first edge sampling `btn_in`=1, with `btn_in` held high. `btn_level`, `press_pulse` and `led_out` update at edge DEBOUNCE_CYCLES+3.
- Release latency is identical, DEBOUNCE_CYCLES+3 edges.
- Any low `sync2` sample during WAIT_HIGH restarts qualification from IDLE_LOW. Any high `sync2` sample during WAIT_LOW restarts qualification from IDLE_HIGH.
- All outputs are registered, with no combinational path from `btn_in`.
- Pulse rate limit: at most one `press_pulse` per 2·(DEBOUNCE_CYCLES+1) cycles.

## Configuration
- Macro: `BUTTON_DEBOUNCE_TOGGLE_EN`.
- Defined (toggle mode):
  - `led_out` inverts on the same edge that sets `press_pulse`.
  - `led_out` is unchanged on release.
- Undefined (follow mode):
  - `led_out` is updated on the same edges as `btn_level` and always equals it.
  - Toggle register is not synthesized.

## Test plan
Use DEBOUNCE_CYCLES=4 and CNT_WIDTH=3 throughout.
- Reset with button held: `rst`=1 for 3 edges while `btn_in`=1 → all outputs 0. After `rst` deasserts, `btn_level`=1 and `press_pulse` pulses exactly at the 7th edge after release of reset.
- Clean press: `btn_in` 0→1 sampled at edge 1 and held 20 cycles → `btn_level`=1 and `press_pulse`=1 after edge 7. `press_pulse`=0 after edge 8. `led_out`=1 in both modes.
- Short glitch: `btn_in`=1 for 4 cycles, then 0 → `btn_level`, `press_pulse` and `led_out` stay 0 throughout.
- Bounce: `btn_in` alternates each cycle for 10 cycles, then stays 1 → exactly one `press_pulse`. `btn_level` rises 7 edges after the last transition.
- Two full press/release cycles, each phase held 20 cycles:
  - Toggle mode: `led_out` sequence 0→1→0, with changes only on press edges.
  - Follow mode: `led_out` mirrors `btn_level` (1,0,1,0).
- Reset mid-qualification: `rst`=1 at edge 4 of WAIT_HIGH → outputs 0, no `press_pulse`. Qualification restarts from IDLE_LOW after `rst` deasserts.
